// File: rtl/sw_debounce_pkg.sv
// Shared types and sizing helper for the slide-switch debouncer.
package sw_debounce_pkg;

   typedef enum logic {DB_IDLE, DB_PENDING} db_state_t;

   localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

   function automatic int cnt_width(input int stable_cycles);
      if (stable_cycles < 1)
         return 1;
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-FF synchronizer, stability FSM/counter, optional edge pulses.
// Edge pulse registers exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_ch
   import sw_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
)(
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic      s1;
   logic      s2;
   db_state_t state;
   logic [CW-1:0] cnt;
   logic      upd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // A single-cycle requirement commits straight from IDLE, so PENDING is never held.
   assign upd = (s2 != db) &&
                (((state == DB_IDLE) && (CNT_LAST == '0)) ||
                 ((state == DB_PENDING) && (cnt == CNT_LAST)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DB_IDLE;
         cnt   <= '0;
         db    <= 1'b0;
      end else begin
         case (state)
            DB_IDLE: begin
               if (upd) begin
                  db  <= s2;
                  cnt <= '0;
               end else if (s2 != db) begin
                  state <= DB_PENDING;
                  cnt   <= CW'(1);
               end else begin
                  cnt <= '0;
               end
            end
            DB_PENDING: begin
               if (s2 == db) begin
                  state <= DB_IDLE;
                  cnt   <= '0;
               end else if (upd) begin
                  db    <= s2;
                  cnt   <= '0;
                  state <= DB_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= DB_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   // Pulses line up with the cycle in which the new debounced level is first visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= upd & s2;
         fall <= upd & ~s2;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW slide switches in parallel; edge pulses built only with SW_DEBOUNCE_EDGE_EN.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int N_SW          = 16,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] sw_raw,
   output logic [N_SW-1:0] sw_db,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall
);

   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      sw_debounce_ch #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (sw_raw[i]),
         .db   (sw_db[i]),
         .rise (sw_rise[i]),
         .fall (sw_fall[i])
      );
   end

endmodule
